// File: rtl/afu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// afu_irq_arbiter: latches AFU interrupt requests and offers them round-robin
// to the MSI-X stage over valid/ready. Optional feature macro: AFU_IRQ_MASK_EN.
// Revision: 1.0
// ============================================================================
module afu_irq_arbiter #(
  parameter int NUM_AFU_INTERRUPTS   = 7,
  parameter int L_NUM_AFU_INTERRUPTS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_AFU_INTERRUPTS-1:0]   afu_irq_in,
  input  logic                            irq_ready,
`ifdef AFU_IRQ_MASK_EN
  input  logic [NUM_AFU_INTERRUPTS-1:0]   irq_mask,
`endif
  output logic                            irq_valid,
  output logic [L_NUM_AFU_INTERRUPTS-1:0] irq_vector,
  output logic [NUM_AFU_INTERRUPTS-1:0]   irq_pending,
  output logic [15:0]                     drop_cnt
);

  localparam int N = NUM_AFU_INTERRUPTS;
  localparam int L = L_NUM_AFU_INTERRUPTS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           irq_valid_q, irq_valid_d;
  logic [L-1:0]   irq_vector_q, irq_vector_d;
  logic [L-1:0]   last_grant_q, last_grant_d;

  logic           handshake;
  logic [N-1:0]   eligible;
  logic [N-1:0]   clr;
  logic [N-1:0]   drop_bits;
  logic [L:0]     drop_num;
  logic [16:0]    drop_sum;
  logic           found_hi, found_lo;
  logic [L-1:0]   winner_hi, winner_lo;

  assign handshake = irq_valid_q && irq_ready;

`ifdef AFU_IRQ_MASK_EN
  assign eligible = pending_q & ~irq_mask;
`else
  assign eligible = pending_q;
`endif

  // A re-request landing on the vector being acknowledged re-arms it rather than dropping.
  always_comb begin
    clr       = '0;
    drop_bits = '0;
    drop_num  = '0;
    for (int i = 0; i < N; i++) begin
      clr[i]       = handshake && (irq_vector_q == L'(i));
      drop_bits[i] = afu_irq_in[i] && pending_q[i] && !clr[i];
      drop_num     = drop_num + (L+1)'(drop_bits[i]);
    end
    pending_d  = (pending_q & ~clr) | afu_irq_in;
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_num);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Split search: indices above last_grant win first, otherwise wrap to the lowest.
  always_comb begin
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    winner_hi = '0;
    winner_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i > int'(last_grant_q)) begin
          found_hi  = 1'b1;
          winner_hi = L'(i);
        end else begin
          found_lo  = 1'b1;
          winner_lo = L'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_valid_d  = irq_valid_q;
    irq_vector_d = irq_vector_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (found_hi || found_lo) begin
          irq_valid_d  = 1'b1;
          irq_vector_d = found_hi ? winner_hi : winner_lo;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          irq_valid_d  = 1'b0;
          last_grant_d = irq_vector_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      drop_cnt_q   <= '0;
      irq_valid_q  <= 1'b0;
      irq_vector_q <= '0;
      last_grant_q <= L'(N - 1);
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      drop_cnt_q   <= drop_cnt_d;
      irq_valid_q  <= irq_valid_d;
      irq_vector_q <= irq_vector_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign irq_valid   = irq_valid_q;
  assign irq_vector  = irq_vector_q;
  assign irq_pending = pending_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_afu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// tb_afu_irq_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of the arbiter. Revision: 1.0
// ============================================================================
module tb_afu_irq_arbiter;
  localparam int N = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  afu_irq_in;
  logic        irq_ready;
  logic        irq_valid;
  logic [2:0]  irq_vector;
  logic [6:0]  irq_pending;
  logic [15:0] drop_cnt;
`ifdef AFU_IRQ_MASK_EN
  logic [6:0]  irq_mask;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [6:0]  m_pend;
  logic        m_valid;
  logic [2:0]  m_vec;
  int          m_lg;
  int          m_drop;

  always #5 clk = ~clk;

  afu_irq_arbiter #(
    .NUM_AFU_INTERRUPTS  (7),
    .L_NUM_AFU_INTERRUPTS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .afu_irq_in (afu_irq_in),
    .irq_ready  (irq_ready),
`ifdef AFU_IRQ_MASK_EN
    .irq_mask   (irq_mask),
`endif
    .irq_valid  (irq_valid),
    .irq_vector (irq_vector),
    .irq_pending(irq_pending),
    .drop_cnt   (drop_cnt)
  );

  // One clock edge of the model, using the inputs as they stand at that edge.
  task automatic model_step();
    logic       hs;
    logic [6:0] elig;
    logic [6:0] nxt;
    bit         found;
    int         idx;
    hs = m_valid && irq_ready;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_vec   = '0;
      m_lg    = N - 1;
      m_drop  = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (afu_irq_in[i] && m_pend[i] && !(hs && int'(m_vec) == i))
          m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
      end
      nxt = m_pend;
      if (hs) nxt[m_vec] = 1'b0;
      nxt = nxt | afu_irq_in;
      if (hs) begin
        m_lg    = int'(m_vec);
        m_valid = 1'b0;
      end else if (!m_valid) begin
`ifdef AFU_IRQ_MASK_EN
        elig = m_pend & ~irq_mask;
`else
        elig = m_pend;
`endif
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_lg + 1 + k) % N;
          if (!found && elig[idx]) begin
            found   = 1;
            m_vec   = 3'(idx);
            m_valid = 1'b1;
          end
        end
      end
      m_pend = nxt;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    afu_irq_in = '0;
    irq_ready  = 1'b0;
`ifdef AFU_IRQ_MASK_EN
    irq_mask   = '0;
`endif
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", irq_valid); end
    n_cmp++; if (irq_vector !== 3'd0) begin n_err++; $display("FAIL reset_vector: got %0d expected 0", irq_vector); end
    n_cmp++; if (irq_pending !== 7'h00) begin n_err++; $display("FAIL reset_pending: got %h expected 00", irq_pending); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_single_pulse();
    do_reset();
    irq_ready  = 1'b1;
    afu_irq_in = 7'h04;
    cycle();
    afu_irq_in = '0;
    n_cmp++; if (irq_pending !== 7'h04) begin n_err++; $display("FAIL pulse_pending_set: got %h expected 04", irq_pending); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL pulse_valid_early: got %b expected 0", irq_valid); end
    cycle();
    n_cmp++; if (irq_valid !== 1'b1) begin n_err++; $display("FAIL pulse_valid: got %b expected 1", irq_valid); end
    n_cmp++; if (irq_vector !== 3'd2) begin n_err++; $display("FAIL pulse_vector: got %0d expected 2", irq_vector); end
    cycle();
    cycle();
    n_cmp++; if (irq_pending !== 7'h00) begin n_err++; $display("FAIL pulse_pending_clr: got %h expected 00", irq_pending); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL pulse_valid_after: got %b expected 0", irq_valid); end
  endtask

  task automatic test_all_vectors();
    int got_vec[$];
    int got_cyc[$];
    do_reset();
    irq_ready  = 1'b1;
    afu_irq_in = 7'h7F;
    cycle();
    afu_irq_in = '0;
    for (int c = 0; c < 24; c++) begin
      if (irq_valid) begin
        got_vec.push_back(int'(irq_vector));
        got_cyc.push_back(c);
      end
      cycle();
    end
    n_cmp++; if (got_vec.size() != 7) begin n_err++; $display("FAIL all_count: got %0d issues expected 7", got_vec.size()); end
    for (int i = 0; i < got_vec.size(); i++) begin
      n_cmp++; if (got_vec[i] != i) begin n_err++; $display("FAIL all_order[%0d]: got %0d expected %0d", i, got_vec[i], i); end
      if (i > 0) begin
        n_cmp++; if (got_cyc[i] - got_cyc[i-1] != 2) begin n_err++; $display("FAIL all_spacing[%0d]: got %0d expected 2", i, got_cyc[i] - got_cyc[i-1]); end
      end
    end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL all_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    int hs_count;
    int unstable;
    do_reset();
    irq_ready  = 1'b0;
    afu_irq_in = 7'h08;
    cycle();
    afu_irq_in = '0;
    cycle();
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      afu_irq_in = (c % 2 == 0 && c < 8) ? 7'h08 : 7'h00;
      cycle();
      if (irq_valid !== 1'b1 || irq_vector !== 3'd3) unstable++;
    end
    afu_irq_in = '0;
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
    n_cmp++; if (drop_cnt !== 16'd4) begin n_err++; $display("FAIL bp_drop: got %0d expected 4", drop_cnt); end
    irq_ready = 1'b1;
    hs_count  = 0;
    for (int c = 0; c < 6; c++) begin
      if (irq_valid && irq_ready) hs_count++;
      cycle();
    end
    n_cmp++; if (hs_count != 1) begin n_err++; $display("FAIL bp_issues: got %0d expected 1", hs_count); end
    n_cmp++; if (irq_pending !== 7'h00) begin n_err++; $display("FAIL bp_pending: got %h expected 00", irq_pending); end
  endtask

  task automatic test_rerequest_on_handshake();
    do_reset();
    irq_ready  = 1'b1;
    afu_irq_in = 7'h20;
    cycle();
    afu_irq_in = '0;
    cycle();
    n_cmp++; if (irq_valid !== 1'b1 || irq_vector !== 3'd5) begin n_err++; $display("FAIL rereq_first: got valid=%b vec=%0d expected 1/5", irq_valid, irq_vector); end
    afu_irq_in = 7'h20;
    cycle();
    afu_irq_in = '0;
    n_cmp++; if (irq_pending !== 7'h20) begin n_err++; $display("FAIL rereq_pending: got %h expected 20", irq_pending); end
    cycle();
    n_cmp++; if (irq_valid !== 1'b1 || irq_vector !== 3'd5) begin n_err++; $display("FAIL rereq_second: got valid=%b vec=%0d expected 1/5", irq_valid, irq_vector); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rereq_drop: got %0d expected 0", drop_cnt); end
    cycle();
    cycle();
  endtask

  task automatic test_reset_during_issue();
    do_reset();
    irq_ready  = 1'b0;
    afu_irq_in = 7'h02;
    cycle();
    cycle();
    afu_irq_in = '0;
    n_cmp++; if (irq_valid !== 1'b1 || drop_cnt !== 16'd1) begin n_err++; $display("FAIL rst_issue_pre: got valid=%b drop=%0d expected 1/1", irq_valid, drop_cnt); end
    rst        = 1'b1;
    afu_irq_in = 7'h7F;
    cycle();
    rst        = 1'b0;
    n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL rst_issue_valid: got %b expected 0", irq_valid); end
    n_cmp++; if (irq_pending !== 7'h00) begin n_err++; $display("FAIL rst_issue_pending: got %h expected 00", irq_pending); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_issue_drop: got %0d expected 0", drop_cnt); end
    afu_irq_in = 7'h42;
    cycle();
    afu_irq_in = '0;
    cycle();
    n_cmp++; if (irq_valid !== 1'b1 || irq_vector !== 3'd1) begin n_err++; $display("FAIL rst_issue_first: got valid=%b vec=%0d expected 1/1", irq_valid, irq_vector); end
    irq_ready = 1'b1;
    cycle();
    cycle();
    n_cmp++; if (irq_valid !== 1'b1 || irq_vector !== 3'd6) begin n_err++; $display("FAIL rst_issue_second: got valid=%b vec=%0d expected 1/6", irq_valid, irq_vector); end
    cycle();
  endtask

  task automatic test_drop_saturation();
    do_reset();
    irq_ready  = 1'b0;
    afu_irq_in = 7'h7F;
    cycle();
    for (int c = 0; c < 9362; c++) cycle();
    n_cmp++; if (drop_cnt !== 16'd65534) begin n_err++; $display("FAIL sat_before: got %0d expected 65534", drop_cnt); end
    cycle();
    n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %0d expected 65535", drop_cnt); end
    cycle();
    cycle();
    n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %0d expected 65535", drop_cnt); end
    afu_irq_in = '0;
  endtask

`ifdef AFU_IRQ_MASK_EN
  task automatic test_mask();
    int issues;
    int bad_vec;
    bit saw0;
    do_reset();
    irq_mask   = 7'h01;
    irq_ready  = 1'b1;
    afu_irq_in = 7'h03;
    cycle();
    afu_irq_in = '0;
    issues  = 0;
    bad_vec = 0;
    for (int c = 0; c < 8; c++) begin
      if (irq_valid) begin
        issues++;
        if (irq_vector !== 3'd1) bad_vec++;
      end
      cycle();
    end
    n_cmp++; if (issues != 1 || bad_vec != 0) begin n_err++; $display("FAIL mask_only1: got %0d issues %0d wrong expected 1/0", issues, bad_vec); end
    n_cmp++; if (irq_pending !== 7'h01) begin n_err++; $display("FAIL mask_pending: got %h expected 01", irq_pending); end
    irq_mask = 7'h00;
    saw0     = 0;
    for (int c = 0; c < 4; c++) begin
      if (irq_valid && irq_vector == 3'd0) saw0 = 1;
      cycle();
    end
    n_cmp++; if (!saw0) begin n_err++; $display("FAIL mask_unmask: got no issue expected vector 0"); end
    do_reset();
    afu_irq_in = 7'h04;
    cycle();
    afu_irq_in = '0;
    cycle();
    irq_mask = 7'h04;
    for (int c = 0; c < 3; c++) cycle();
    n_cmp++; if (irq_valid !== 1'b1 || irq_vector !== 3'd2) begin n_err++; $display("FAIL mask_offer_held: got valid=%b vec=%0d expected 1/2", irq_valid, irq_vector); end
    irq_ready = 1'b1;
    cycle();
    n_cmp++; if (irq_valid !== 1'b0 || irq_pending !== 7'h00) begin n_err++; $display("FAIL mask_offer_done: got valid=%b pend=%h expected 0/00", irq_valid, irq_pending); end
    irq_mask = 7'h00;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) afu_irq_in[i] = ($urandom_range(0, 5) == 0);
      irq_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 79) == 0);
`ifdef AFU_IRQ_MASK_EN
      if ($urandom_range(0, 15) == 0) irq_mask = 7'($urandom_range(0, 127));
`endif
      cycle();
      n_cmp++; if (irq_valid !== m_valid) begin n_err++; $display("FAIL rand_valid@%0d: got %b expected %b", c, irq_valid, m_valid); end
      n_cmp++; if (irq_pending !== m_pend) begin n_err++; $display("FAIL rand_pending@%0d: got %h expected %h", c, irq_pending, m_pend); end
      n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_err++; $display("FAIL rand_drop@%0d: got %0d expected %0d", c, drop_cnt, m_drop); end
      if (m_valid) begin
        n_cmp++; if (irq_vector !== m_vec) begin n_err++; $display("FAIL rand_vector@%0d: got %0d expected %0d", c, irq_vector, m_vec); end
      end
    end
    rst        = 1'b0;
    afu_irq_in = '0;
  endtask

  initial begin
    rst        = 1'b1;
    afu_irq_in = '0;
    irq_ready  = 1'b0;
`ifdef AFU_IRQ_MASK_EN
    irq_mask   = '0;
`endif
    m_pend  = '0;
    m_valid = 1'b0;
    m_vec   = '0;
    m_lg    = N - 1;
    m_drop  = 0;
    @(negedge clk);
    test_reset();
    test_single_pulse();
    test_all_vectors();
    test_backpressure();
    test_rerequest_on_handshake();
    test_reset_during_issue();
`ifdef AFU_IRQ_MASK_EN
    test_mask();
`endif
    test_random();
    test_drop_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
